// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared types and helpers for the multiple-retirement row scheduler
package mure_pkg;

  localparam int ITYPE_LEN = 3;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [1:0]           priv;
  } uop_entry_s;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  // Exception/interrupt lanes terminate the commit row.
  function automatic logic is_special(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/mure_lane_finder.sv
// rtl/mure_lane_finder.sv - first eligible lane at or above a start index
module mure_lane_finder #(
  parameter int NRET = 2,
  parameter int LW   = $clog2(NRET) + 1
) (
  input  logic [NRET-1:0] elig_i,
  input  logic [LW-1:0]   start_i,
  output logic            found_o,
  output logic [LW-1:0]   sel_o,
  output logic            more_after_o
);

  always_comb begin
    found_o      = 1'b0;
    sel_o        = '0;
    more_after_o = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (elig_i[i] && (LW'(i) >= start_i)) begin
        if (!found_o) begin
          found_o = 1'b1;
          sel_o   = LW'(i);
        end else begin
          more_after_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mure_row_scheduler.sv
// rtl/mure_row_scheduler.sv - walks one commit row lane by lane and hands uops to the block fsm
module mure_row_scheduler
  import mure_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int CNT_W = 16,
  parameter int LW    = $clog2(NRET) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  uop_entry_s [NRET-1:0]       head_i,
  input  logic [NRET-1:0]             empty_i,
  output logic                        pop_o,
  output logic                        uop_valid_o,
  input  logic                        uop_ready_i,
  output uop_entry_s                  uop_o,
  output logic [LW-1:0]               lane_o,
  output logic                        row_last_o,
  output logic                        desync_err_o,
  output logic [CNT_W-1:0]            issued_cnt_o,
  output logic [CNT_W-1:0]            dropped_cnt_o
);

  state_e           r_state, w_state_nxt;
  logic [LW-1:0]    r_idx, w_idx_nxt;
  logic             r_row_issued, w_row_issued_nxt;
  logic             r_desync;
  logic [CNT_W-1:0] r_issued_cnt, r_dropped_cnt;
  logic             w_drop;

  logic [NRET-1:0]  w_elig;
  logic             w_found, w_more;
  logic [LW-1:0]    w_sel;
  uop_entry_s       w_head;

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      w_elig[i] = head_i[i].valid || is_special(head_i[i].itype);
    end
  end

  mure_lane_finder #(.NRET(NRET), .LW(LW)) u_finder (
    .elig_i       (w_elig),
    .start_i      (r_idx),
    .found_o      (w_found),
    .sel_o        (w_sel),
    .more_after_o (w_more)
  );

  always_comb begin
    w_head = '0;
    for (int i = 0; i < NRET; i++) begin
      if (LW'(i) == w_sel) w_head = head_i[i];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_row_issued_nxt = r_row_issued;
    w_drop           = 1'b0;
    pop_o            = 1'b0;
    uop_valid_o      = 1'b0;
    uop_o            = '0;
    lane_o           = '0;
    row_last_o       = 1'b0;
    if (flush_i) begin
      w_state_nxt      = ST_IDLE;
      w_idx_nxt        = '0;
      w_row_issued_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!empty_i[0]) begin
            w_state_nxt = ST_ISSUE;
            w_idx_nxt   = '0;
          end
        end
        default: begin
          // After a pop we stay here; an empty FIFO is only visible now, so fall back to IDLE.
          if (empty_i[0]) begin
            w_state_nxt      = ST_IDLE;
            w_idx_nxt        = '0;
            w_row_issued_nxt = 1'b0;
          end else if (w_found) begin
            uop_valid_o = 1'b1;
            uop_o       = w_head;
            lane_o      = w_sel;
            row_last_o  = is_special(w_head.itype) || !w_more;
            if (uop_ready_i) begin
              if (row_last_o) begin
                pop_o            = 1'b1;
                w_idx_nxt        = '0;
                w_row_issued_nxt = 1'b0;
              end else begin
                w_idx_nxt        = w_sel + LW'(1);
                w_row_issued_nxt = 1'b1;
              end
            end
          end else begin
            pop_o            = 1'b1;
            w_idx_nxt        = '0;
            w_drop           = !r_row_issued;
            w_row_issued_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_row_issued  <= 1'b0;
      r_desync      <= 1'b0;
      r_issued_cnt  <= '0;
      r_dropped_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_row_issued <= w_row_issued_nxt;
      if ((empty_i != '0) && (empty_i != '1)) r_desync <= 1'b1;
      if (uop_valid_o && uop_ready_i && (r_issued_cnt != '1))
        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      if (w_drop && (r_dropped_cnt != '1))
        r_dropped_cnt <= r_dropped_cnt + CNT_W'(1);
    end
  end

  assign desync_err_o  = r_desync;
  assign issued_cnt_o  = r_issued_cnt;
  assign dropped_cnt_o = r_dropped_cnt;

endmodule

// File: tb/tb_mure_row_scheduler.sv
// tb/tb_mure_row_scheduler.sv - directed vector bench for the row scheduler
module tb_mure_row_scheduler;
  import mure_pkg::*;

  localparam int NRET  = 2;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(NRET) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  uop_entry_s [NRET-1:0] head;
  logic [NRET-1:0]       empty;
  logic                  pop;
  logic                  uop_valid;
  logic                  uop_ready;
  uop_entry_s            uop;
  logic [LW-1:0]         lane;
  logic                  row_last;
  logic                  desync;
  logic [CNT_W-1:0]      issued_cnt;
  logic [CNT_W-1:0]      dropped_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mure_row_scheduler #(.NRET(NRET), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .head_i        (head),
    .empty_i       (empty),
    .pop_o         (pop),
    .uop_valid_o   (uop_valid),
    .uop_ready_i   (uop_ready),
    .uop_o         (uop),
    .lane_o        (lane),
    .row_last_o    (row_last),
    .desync_err_o  (desync),
    .issued_cnt_o  (issued_cnt),
    .dropped_cnt_o (dropped_cnt)
  );

  typedef struct {
    logic       v0;
    logic [2:0] t0;
    logic       v1;
    logic [2:0] t1;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_lane;
    logic       e_last;
    logic       e_pop;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_row(input logic v0, input logic [2:0] t0, input logic [31:0] pc0,
                         input logic v1, input logic [2:0] t1, input logic [31:0] pc1);
    head[0] = '{valid: v0, pc: pc0, itype: t0, compressed: 1'b0, priv: 2'd3};
    head[1] = '{valid: v1, pc: pc1, itype: t1, compressed: 1'b1, priv: 2'd3};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [1:0] l,
                         input logic last, input logic p, input logic [31:0] pc);
    #1;
    chk({name, ".valid"}, 64'(uop_valid), 64'(v));
    chk({name, ".lane"},  64'(lane),      64'(l));
    chk({name, ".last"},  64'(row_last),  64'(last));
    chk({name, ".pop"},   64'(pop),       64'(p));
    chk({name, ".pc"},    64'(uop.pc),    64'(pc));
  endtask

  int exp_issued;
  int exp_dropped;
  logic [31:0] base;
  logic [31:0] e_pc;

  initial begin
    //            v0    t0    v1    t1    rdy   ev    el    elast epop
    vecs[0] = '{1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 3'd2, 1'b1, 3'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; uop_ready = 1'b0; empty = '1;
    set_row(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #12;
    chk("rst.pop",     64'(pop),         64'd0);
    chk("rst.valid",   64'(uop_valid),   64'd0);
    chk("rst.last",    64'(row_last),    64'd0);
    chk("rst.desync",  64'(desync),      64'd0);
    chk("rst.uop",     64'(uop),         64'd0);
    chk("rst.lane",    64'(lane),        64'd0);
    chk("rst.issued",  64'(issued_cnt),  64'd0);
    chk("rst.dropped", 64'(dropped_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    exp_issued = 0; exp_dropped = 0;
    foreach (vecs[i]) begin
      base = 32'h1000 + 32'(i) * 32'h10;
      flush = 1'b1; uop_ready = 1'b0; empty = '0;
      set_row(vecs[i].v0, vecs[i].t0, base, vecs[i].v1, vecs[i].t1, base + 32'h4);
      tick();
      flush = 1'b0;
      chk_out($sformatf("v%0d.idle", i), 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
      tick();
      uop_ready = vecs[i].rdy;
      e_pc = vecs[i].e_valid ? base + 32'(vecs[i].e_lane) * 32'h4 : 32'h0;
      chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_lane, vecs[i].e_last,
              vecs[i].e_pop, e_pc);
      if (vecs[i].e_valid && vecs[i].rdy) exp_issued++;
      if (!vecs[i].e_valid) exp_dropped++;
      tick();
      uop_ready = 1'b0;
    end
    chk("tbl.issued",  64'(issued_cnt),  64'(exp_issued));
    chk("tbl.dropped", 64'(dropped_cnt), 64'(exp_dropped));

    // Full two-lane row, then FIFO empties after the pop.
    flush = 1'b1; tick(); flush = 1'b0;
    set_row(1'b1, 3'd0, 32'h2000, 1'b1, 3'd4, 32'h2004); empty = '0; uop_ready = 1'b1;
    tick();
    chk_out("r1.l0", 1'b1, 2'd0, 1'b0, 1'b0, 32'h2000);
    tick();
    chk_out("r1.l1", 1'b1, 2'd1, 1'b1, 1'b1, 32'h2004);
    tick();
    empty = '1; set_row(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    chk_out("r1.empty", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("r1.idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);

    // Backpressure hold on lane 0 for five cycles.
    uop_ready = 1'b0; empty = '0;
    set_row(1'b1, 3'd0, 32'h3000, 1'b1, 3'd0, 32'h3004);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk_out($sformatf("hold%0d", c), 1'b1, 2'd0, 1'b0, 1'b0, 32'h3000);
      tick();
    end
    uop_ready = 1'b1;
    chk_out("hold.go", 1'b1, 2'd0, 1'b0, 1'b0, 32'h3000);
    tick();
    chk_out("hold.l1", 1'b1, 2'd1, 1'b1, 1'b1, 32'h3004);
    exp_issued = int'(issued_cnt) + 1;
    tick();

    // Three back-to-back rows, no gaps.
    for (int r = 0; r < 3; r++) begin
      base = 32'h4000 + 32'(r) * 32'h10;
      set_row(1'b1, 3'd0, base, 1'b1, 3'd0, base + 32'h4);
      chk_out($sformatf("b2b%0d.l0", r), 1'b1, 2'd0, 1'b0, 1'b0, base);
      tick();
      chk_out($sformatf("b2b%0d.l1", r), 1'b1, 2'd1, 1'b1, 1'b1, base + 32'h4);
      tick();
    end
    chk("b2b.issued", 64'(issued_cnt), 64'(exp_issued + 6));

    // Flush while lane 1 is pending.
    set_row(1'b1, 3'd0, 32'h5000, 1'b1, 3'd0, 32'h5004);
    chk_out("fl.l0", 1'b1, 2'd0, 1'b0, 1'b0, 32'h5000);
    tick();
    flush = 1'b1;
    chk_out("fl.flush", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b0;
    chk_out("fl.idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
    chk("fl.issued", 64'(issued_cnt), 64'(exp_issued + 7));

    // Desync is sticky until reset.
    uop_ready = 1'b0; empty = 2'b01;
    tick();
    empty = '1;
    chk("dsync.set", 64'(desync), 64'd1);
    tick(); tick();
    chk("dsync.hold", 64'(desync), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("dsync.rst",   64'(desync),      64'd0);
    chk("rst2.issued", 64'(issued_cnt),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
